// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
//   Register-file constants shared by rf_32 and rf_write_arbiter: data width,
//   index width, number of architectural registers and the hard-wired zero
//   register index.
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned REG_SIZE     = 32;
    localparam int unsigned INDEX_SIZE   = 5;
    localparam int unsigned REGFILE_SIZE = 2 ** INDEX_SIZE;

    // Register 0 reads as zero; writes to it are discarded.
    localparam logic [INDEX_SIZE-1:0] ZERO = '0;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for NUM_REQ requesters. The grant is combinational
//   from (req_valid, r_ptr); the search starts at r_ptr+1 (mod NUM_REQ) and the
//   first valid requester wins. On a grant the pointer moves to the winner at
//   the next posedge, so a continuously valid requester waits at most
//   NUM_REQ-1 cycles.
//
// Ports
//   clock      in   1        posedge clock
//   reset_n    in   1        asynchronous active-low reset (ptr -> NUM_REQ-1)
//   req_valid  in   NUM_REQ  request vector
//   grant      out  NUM_REQ  one-hot grant (all zero when nothing is valid)
//   grant_any  out  1        OR of grant
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_any
);

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_cand;

    // Walk the requesters starting just after the last winner; the first
    // valid one found takes the grant.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_cand = PTR_W'((32'(r_ptr) + off) % NUM_REQ);
            if (!w_any && req_valid[w_cand]) begin
                w_grant[w_cand] = 1'b1;
                w_any           = 1'b1;
                w_idx           = w_cand;
            end
        end
    end

    // Reset value NUM_REQ-1 makes requester 0 the first in line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (w_any) begin
            r_ptr <= w_idx;
        end
    end

    assign grant     = w_grant;
    assign grant_any = w_any;

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the single rf_32 write port among NUM_REQ writeback sources
//   (ALU, load unit, mul/div). A round-robin arbiter grants one requester per
//   cycle over a valid/ready handshake; the winning write is registered onto
//   the write port (latency 1). A pending-write scoreboard lets the issue
//   stage detect RAW hazards.
//
// Ports
//   clock             in   1                    posedge clock
//   reset_n           in   1                    asynchronous active-low reset
//   req_valid         in   NUM_REQ              requester i has a write
//   req_addr          in   NUM_REQ*INDEX_SIZE   dest index, slice i
//   req_data          in   NUM_REQ*REG_SIZE     write data, slice i
//   req_ready         out  NUM_REQ              one-hot grant
//   reserve_valid     in   1                    issue stage claims a dest
//   reserve_addr      in   INDEX_SIZE           claimed dest
//   reserve_conflict  out  1                    claim hit a pending register
//   pending_mask      out  REGFILE_SIZE         bit r = write to r outstanding
//   write_enabled     out  1                    rf_32 write enable
//   write_addr        out  INDEX_SIZE           rf_32 write index
//   write_data        out  REG_SIZE             rf_32 write data
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 3,
    parameter  int unsigned REG_SIZE     = rf_pkg::REG_SIZE,
    parameter  int unsigned INDEX_SIZE   = rf_pkg::INDEX_SIZE,
    localparam int unsigned REGFILE_SIZE = 2 ** INDEX_SIZE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*INDEX_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*REG_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          reserve_valid,
    input  logic [INDEX_SIZE-1:0]         reserve_addr,
    output logic                          reserve_conflict,
    output logic [REGFILE_SIZE-1:0]       pending_mask,
    output logic                          write_enabled,
    output logic [INDEX_SIZE-1:0]         write_addr,
    output logic [REG_SIZE-1:0]           write_data
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_grant;
    logic               w_grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .grant     (w_grant),
        .grant_any (w_grant_any)
    );

    assign req_ready = w_grant;

    // One-hot grant makes an AND-OR mux sufficient for the winner's payload.
    logic [INDEX_SIZE-1:0] w_sel_addr;
    logic [REG_SIZE-1:0]   w_sel_data;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | req_addr[i*INDEX_SIZE +: INDEX_SIZE];
                w_sel_data = w_sel_data | req_data[i*REG_SIZE +: REG_SIZE];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register (write port to rf_32)
    // ------------------------------------------------------------------
    logic                  r_we;
    logic [INDEX_SIZE-1:0] r_waddr;
    logic [REG_SIZE-1:0]   r_wdata;

    // A grant to register 0 completes the handshake but never enables the
    // write; with no grant, addr/data hold and only the enable drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_grant_any) begin
            r_we    <= (w_sel_addr != INDEX_SIZE'(ZERO));
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign write_enabled = r_we;
    assign write_addr    = r_waddr;
    assign write_data    = r_wdata;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    logic [REGFILE_SIZE-1:0] r_pending;
    logic                    r_conflict;
    logic [REGFILE_SIZE-1:0] w_clr_vec;
    logic [REGFILE_SIZE-1:0] w_set_vec;
    logic [REGFILE_SIZE-1:0] w_pending_nxt;
    logic                    w_rsv_hit;
    logic                    w_commit_same;
    logic                    w_conflict_nxt;

    assign w_rsv_hit     = reserve_valid && (reserve_addr != INDEX_SIZE'(ZERO));
    assign w_commit_same = r_we && (r_waddr == reserve_addr);

    // Set is applied after clear, so a reservation landing on the commit
    // edge of the same index keeps the bit (the newer producer owns it).
    always_comb begin
        w_clr_vec = '0;
        w_set_vec = '0;
        if (r_we) begin
            w_clr_vec[r_waddr] = 1'b1;
        end
        if (w_rsv_hit) begin
            w_set_vec[reserve_addr] = 1'b1;
        end
        w_pending_nxt    = (r_pending & ~w_clr_vec) | w_set_vec;
        w_pending_nxt[0] = 1'b0;
    end

    // A second claim on a still-pending register is flagged; a claim that
    // coincides with that register's commit is a fresh reservation instead.
    assign w_conflict_nxt = w_rsv_hit && r_pending[reserve_addr] && !w_commit_same;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    assign pending_mask     = r_pending;
    assign reserve_conflict = r_conflict;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Directed-vector bench for rf_write_arbiter (NUM_REQ=3, 32-bit data,
//   5-bit index). Inputs change just after the falling edge; outputs are
//   sampled 1 time unit later or at the following falling edge. A tiny
//   register-file array stands in for rf_32 to read back committed data.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned RW   = 32;
    localparam int unsigned IW   = 5;
    localparam int unsigned RFS  = 32;

    logic               clock;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*IW-1:0] req_addr;
    logic [NREQ*RW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               reserve_valid;
    logic [IW-1:0]      reserve_addr;
    logic               reserve_conflict;
    logic [RFS-1:0]     pending_mask;
    logic               write_enabled;
    logic [IW-1:0]      write_addr;
    logic [RW-1:0]      write_data;

    int unsigned n_vec;
    int unsigned n_err;

    logic [RW-1:0] tb_rf [RFS];

    rf_write_arbiter #(
        .NUM_REQ    (NREQ),
        .REG_SIZE   (RW),
        .INDEX_SIZE (IW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .reserve_valid    (reserve_valid),
        .reserve_addr     (reserve_addr),
        .reserve_conflict (reserve_conflict),
        .pending_mask     (pending_mask),
        .write_enabled    (write_enabled),
        .write_addr       (write_addr),
        .write_data       (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for rf_32: commits on the posedge where write_enabled is high.
    always @(posedge clock) begin
        if (write_enabled) tb_rf[write_addr] <= write_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic [IW-1:0] a,
                           input logic [RW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*IW +: IW]  = a;
        req_data[i*RW +: RW]  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        req_valid     = '0;
        req_addr      = '0;
        req_data      = '0;
        reserve_valid = 1'b0;
        reserve_addr  = '0;
        for (int i = 0; i < int'(RFS); i++) tb_rf[i] = '0;

        // Reset state
        #2;
        check_eq("rst_we",       64'(write_enabled),    64'd0);
        check_eq("rst_waddr",    64'(write_addr),       64'd0);
        check_eq("rst_wdata",    64'(write_data),       64'd0);
        check_eq("rst_pending",  64'(pending_mask),     64'd0);
        check_eq("rst_conflict", 64'(reserve_conflict), 64'd0);

        // 1. Reset mid-stream
        @(negedge clock);
        reset_n = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++)
            set_req(i, 1'b1, IW'(i + 1), 32'hA000_0000 + i);
        reserve_valid = 1'b1;
        reserve_addr  = 5'd4;
        #1;
        check_eq("t1_first_grant", 64'(req_ready), 64'b001);
        @(negedge clock);
        reserve_valid = 1'b0;
        check_eq("t1_we",       64'(write_enabled), 64'd1);
        check_eq("t1_waddr",    64'(write_addr),    64'd1);
        check_eq("t1_pending",  64'(pending_mask),  64'h10);
        check_eq("t1_grant2",   64'(req_ready),     64'b010);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t1_async_we",      64'(write_enabled), 64'd0);
        check_eq("t1_async_waddr",   64'(write_addr),    64'd0);
        check_eq("t1_async_wdata",   64'(write_data),    64'd0);
        check_eq("t1_async_pending", 64'(pending_mask),  64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("t1_post_rst_grant", 64'(req_ready), 64'b001);

        // 2. Round-robin with all three valid
        for (int unsigned k = 0; k < 6; k++) begin
            check_eq("t2_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
            @(negedge clock);
            check_eq("t2_we",    64'(write_enabled), 64'd1);
            check_eq("t2_waddr", 64'(write_addr),    64'((k % 3) + 1));
            check_eq("t2_wdata", 64'(write_data),    64'(32'hA000_0000 + (k % 3)));
        end
        req_valid = '0;
        #1;
        check_eq("t2_idle_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        check_eq("t2_idle_we",      64'(write_enabled), 64'd0);
        check_eq("t2_hold_waddr",   64'(write_addr),    64'd3);
        check_eq("t2_hold_wdata",   64'(write_data),    64'hA000_0002);
        check_eq("t2_pending_zero", 64'(pending_mask),  64'd0);

        // 3. Write to register 0 is discarded
        set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        check_eq("t3_ready", 64'(req_ready), 64'b010);
        @(negedge clock);
        req_valid = '0;
        check_eq("t3_we",      64'(write_enabled), 64'd0);
        check_eq("t3_pending", 64'(pending_mask),  64'd0);

        // 4. Scoreboard set / clear on commit
        reserve_valid = 1'b1;
        reserve_addr  = 5'd5;
        @(negedge clock);
        reserve_valid = 1'b0;
        check_eq("t4_pending_set", 64'(pending_mask),     64'h20);
        check_eq("t4_conflict",    64'(reserve_conflict), 64'd0);
        set_req(2, 1'b1, 5'd5, 32'h1234_5678);
        #1;
        check_eq("t4_ready", 64'(req_ready), 64'b100);
        @(negedge clock);
        req_valid = '0;
        check_eq("t4_we",           64'(write_enabled), 64'd1);
        check_eq("t4_waddr",        64'(write_addr),    64'd5);
        check_eq("t4_pending_hold", 64'(pending_mask),  64'h20);
        @(negedge clock);
        check_eq("t4_pending_clr", 64'(pending_mask),  64'd0);
        check_eq("t4_we_low",      64'(write_enabled), 64'd0);
        check_eq("t4_rf_readback", 64'(tb_rf[5]),      64'h1234_5678);

        // 5. Set and clear of the same index on one edge
        reserve_valid = 1'b1;
        reserve_addr  = 5'd7;
        @(negedge clock);
        reserve_valid = 1'b0;
        check_eq("t5_pending_set", 64'(pending_mask), 64'h80);
        set_req(0, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        check_eq("t5_ready", 64'(req_ready), 64'b001);
        @(negedge clock);
        req_valid     = '0;
        check_eq("t5_we", 64'(write_enabled), 64'd1);
        reserve_valid = 1'b1;
        reserve_addr  = 5'd7;
        @(negedge clock);
        reserve_valid = 1'b0;
        check_eq("t5_pending_kept", 64'(pending_mask),     64'h80);
        check_eq("t5_no_conflict",  64'(reserve_conflict), 64'd0);
        @(negedge clock);
        check_eq("t5_pending_still", 64'(pending_mask),     64'h80);
        check_eq("t5_conflict_low",  64'(reserve_conflict), 64'd0);

        // 6. Double reserve
        reserve_valid = 1'b1;
        reserve_addr  = 5'd9;
        @(negedge clock);
        check_eq("t6_pending_first",  64'(pending_mask),     64'h280);
        check_eq("t6_conflict_first", 64'(reserve_conflict), 64'd0);
        @(negedge clock);
        reserve_valid = 1'b0;
        check_eq("t6_conflict_pulse", 64'(reserve_conflict), 64'd1);
        check_eq("t6_pending_second", 64'(pending_mask),     64'h280);
        @(negedge clock);
        check_eq("t6_conflict_drop", 64'(reserve_conflict), 64'd0);
        check_eq("t6_pending_keep",  64'(pending_mask),     64'h280);

        // Reserving register 0 is ignored
        reserve_valid = 1'b1;
        reserve_addr  = 5'd0;
        @(negedge clock);
        reserve_valid = 1'b0;
        check_eq("r0_pending",  64'(pending_mask),     64'h280);
        check_eq("r0_conflict", 64'(reserve_conflict), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
